// File: rtl/prod_accum_frame.sv
// prod_accum_frame: sums a programmable-length frame of multiplier products
// into a wide accumulator and presents the frame sum on a held result port.
// Latency: the result is valid the cycle after the last product is accepted.
// Backpressure: prod_ready drops while a result waits for acc_ready. Nothing
// decoded from prod_valid or acc_ready reaches prod_ready or acc_valid.
// Ports:
//   clock, reset                 - rising-edge clock, synchronous active-high reset
//   prod_in/prod_valid/prod_ready - product stream in (valid/ready)
//   frame_len                    - products per frame, sampled on the first product
//   clear                        - synchronous abort of the partial frame and pending result
//   acc_out/acc_ovf/acc_valid/acc_ready - frame result out (valid/ready)
//   busy                         - a frame is being accumulated
module prod_accum_frame #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [CNT_W-1:0]  frame_len,
  input  logic              clear,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_ovf,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic             ovf_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum;
  logic             ovf_new;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic             take;

  always_comb begin
    prod_ext = ACC_W'(prod_in);
    // One extra bit captures the carry out of the accumulator.
    sum      = {1'b0, acc} + {1'b0, prod_ext};
    ovf_new  = ovf_q | sum[ACC_W];
    // A zero length would never terminate, so it behaves as a 1-product frame.
    len_eff  = (frame_len == '0) ? CNT_W'(1) : frame_len;
    cnt_inc  = cnt + CNT_W'(1);
    take     = prod_valid & prod_ready;
  end

  // prod_ready, acc_valid and busy are registered alongside the state so they
  // depend only on state. prod_ready stays low during reset and comes up on
  // the first edge after reset is released.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      acc_out    <= '0;
      acc_ovf    <= 1'b0;
      acc_valid  <= 1'b0;
      busy       <= 1'b0;
      prod_ready <= 1'b0;
    end else if (clear) begin
      // acc_out keeps its last value; acc_valid alone qualifies it.
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      ovf_q      <= 1'b0;
      acc_valid  <= 1'b0;
      busy       <= 1'b0;
      prod_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          prod_ready <= 1'b1;
          if (take) begin
            len_q <= len_eff;
            acc   <= prod_ext;
            cnt   <= CNT_W'(1);
            ovf_q <= 1'b0;
            if (len_eff == CNT_W'(1)) begin
              acc_out    <= prod_ext;
              acc_ovf    <= 1'b0;
              acc_valid  <= 1'b1;
              prod_ready <= 1'b0;
              state      <= HOLD;
            end else begin
              busy  <= 1'b1;
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          // A low prod_valid is a stall: acc and cnt simply hold.
          if (take) begin
            acc   <= sum[ACC_W-1:0];
            ovf_q <= ovf_new;
            cnt   <= cnt_inc;
            if (cnt_inc == len_q) begin
              acc_out    <= sum[ACC_W-1:0];
              acc_ovf    <= ovf_new;
              acc_valid  <= 1'b1;
              busy       <= 1'b0;
              prod_ready <= 1'b0;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            acc_valid  <= 1'b0;
            prod_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          acc_valid  <= 1'b0;
          busy       <= 1'b0;
          prod_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum_frame.sv
// Bench for prod_accum_frame: a default-width instance and a 34-bit
// accumulator instance. Expected frame sums come from plain 64-bit
// arithmetic over the products sent.
module tb_prod_accum_frame;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  always #5 clock = ~clock;

  // Default instance (ACC_W=40)
  logic [31:0] prod_in;
  logic        prod_valid;
  logic        prod_ready;
  logic [7:0]  frame_len;
  logic [39:0] acc_out;
  logic        acc_ovf;
  logic        acc_valid;
  logic        acc_ready;
  logic        busy;

  // Narrow instance (ACC_W=34)
  logic [31:0] b_prod_in;
  logic        b_prod_valid;
  logic        b_prod_ready;
  logic [7:0]  b_frame_len;
  logic [33:0] b_acc_out;
  logic        b_acc_ovf;
  logic        b_acc_valid;
  logic        b_acc_ready;
  logic        b_busy;

  prod_accum_frame #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .frame_len(frame_len), .clear(clear),
    .acc_out(acc_out), .acc_ovf(acc_ovf), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .busy(busy));

  prod_accum_frame #(.PROD_W(32), .ACC_W(34), .CNT_W(8)) dut34 (
    .clock(clock), .reset(reset), .prod_in(b_prod_in), .prod_valid(b_prod_valid),
    .prod_ready(b_prod_ready), .frame_len(b_frame_len), .clear(clear),
    .acc_out(b_acc_out), .acc_ovf(b_acc_ovf), .acc_valid(b_acc_valid),
    .acc_ready(b_acc_ready), .busy(b_busy));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  len;
    int          n;
    logic [31:0] p [6];
    logic [63:0] exp_acc;
    logic        exp_ovf;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Offer one product and hold it until it is accepted (bounded).
  task automatic send(input logic [31:0] p);
    bit ok = 0;
    prod_in    = p;
    prod_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (prod_ready) ok = 1;
      tick();
    end
    prod_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic get_res(output logic [63:0] acc, output logic ovf);
    bit ok = 0;
    acc = '0;
    ovf = 1'b0;
    acc_ready = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (acc_valid) begin
        ok  = 1;
        acc = 64'(acc_out);
        ovf = acc_ovf;
      end
      tick();
    end
    acc_ready = 1'b0;
    if (!ok) chk("result_timeout", 64'(0), 64'(1));
  endtask

  task automatic b_send(input logic [31:0] p);
    bit ok = 0;
    b_prod_in    = p;
    b_prod_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (b_prod_ready) ok = 1;
      tick();
    end
    b_prod_valid = 1'b0;
    if (!ok) chk("b_send_timeout", 64'(0), 64'(1));
  endtask

  task automatic b_get(output logic [63:0] acc, output logic ovf);
    bit ok = 0;
    acc = '0;
    ovf = 1'b0;
    b_acc_ready = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (b_acc_valid) begin
        ok  = 1;
        acc = 64'(b_acc_out);
        ovf = b_acc_ovf;
      end
      tick();
    end
    b_acc_ready = 1'b0;
    if (!ok) chk("b_result_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    vec_t        vecs [6];
    logic [63:0] r;
    logic        o;
    logic [63:0] last;

    vecs[0] = '{len: 8'd1, n: 1, p: '{32'd5, 0, 0, 0, 0, 0}, exp_acc: 64'd5, exp_ovf: 1'b0};
    vecs[1] = '{len: 8'd0, n: 1, p: '{32'h12345678, 0, 0, 0, 0, 0}, exp_acc: 64'h12345678, exp_ovf: 1'b0};
    vecs[2] = '{len: 8'd3, n: 3, p: '{32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 0, 0, 0},
                exp_acc: 64'h2FFFA0003, exp_ovf: 1'b0};
    vecs[3] = '{len: 8'd2, n: 2, p: '{32'd7, 32'd9, 0, 0, 0, 0}, exp_acc: 64'd16, exp_ovf: 1'b0};
    vecs[4] = '{len: 8'd4, n: 4, p: '{32'd1, 32'd2, 32'd3, 32'd4, 0, 0}, exp_acc: 64'd10, exp_ovf: 1'b0};
    vecs[5] = '{len: 8'd2, n: 2, p: '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0},
                exp_acc: 64'h1FFFFFFFE, exp_ovf: 1'b0};

    reset = 1'b1; clear = 1'b0;
    prod_in = '0; prod_valid = 1'b0; frame_len = '0; acc_ready = 1'b0;
    b_prod_in = '0; b_prod_valid = 1'b0; b_frame_len = '0; b_acc_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_prod_ready", 64'(prod_ready), 64'(1));
    chk("rst_acc_valid", 64'(acc_valid), 64'(0));
    chk("rst_acc_out", 64'(acc_out), 64'(0));
    chk("rst_acc_ovf", 64'(acc_ovf), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));

    // Table of directed frames
    for (int v = 0; v < 6; v++) begin
      frame_len = vecs[v].len;
      for (int k = 0; k < vecs[v].n; k++) send(vecs[v].p[k]);
      get_res(r, o);
      chk($sformatf("vec%0d_acc", v), r, vecs[v].exp_acc);
      chk($sformatf("vec%0d_ovf", v), 64'(o), 64'(vecs[v].exp_ovf));
    end

    // Reset mid-frame after 2 of 4 products (acc_out is 0x1FFFFFFFE from the table)
    frame_len = 8'd4;
    send(32'd1);
    send(32'd2);
    chk("midrst_busy_before", 64'(busy), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_acc_out", 64'(acc_out), 64'(0));
    chk("midrst_acc_valid", 64'(acc_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_prod_ready", 64'(prod_ready), 64'(0));
    tick();
    frame_len = 8'd1;
    send(32'd5);
    get_res(r, o);
    chk("midrst_next_frame", r, 64'd5);

    // Gap between 2nd and 3rd product; result appears right after the 3rd transfer
    frame_len = 8'd3;
    send(32'hFFFE0001);
    send(32'hFFFE0001);
    tick();
    tick();
    chk("gap_busy", 64'(busy), 64'(1));
    chk("gap_no_valid", 64'(acc_valid), 64'(0));
    acc_ready = 1'b1;
    send(32'hFFFE0001);
    chk("gap_valid_next_cycle", 64'(acc_valid), 64'(1));
    chk("gap_acc", 64'(acc_out), 64'h2FFFA0003);
    chk("gap_ovf", 64'(acc_ovf), 64'(0));
    tick();
    chk("gap_valid_one_cycle", 64'(acc_valid), 64'(0));
    acc_ready = 1'b0;

    // frame_len 0 and 1 go straight to HOLD without a busy cycle
    for (int l = 0; l < 2; l++) begin
      frame_len = 8'(l);
      chk($sformatf("len%0d_ready", l), 64'(prod_ready), 64'(1));
      prod_in = 32'h12345678;
      prod_valid = 1'b1;
      tick();
      prod_valid = 1'b0;
      chk($sformatf("len%0d_busy", l), 64'(busy), 64'(0));
      chk($sformatf("len%0d_valid", l), 64'(acc_valid), 64'(1));
      get_res(r, o);
      chk($sformatf("len%0d_acc", l), r, 64'h12345678);
    end

    // Backpressure: result held, products refused during HOLD
    frame_len = 8'd2;
    send(32'd7);
    send(32'd9);
    prod_in = 32'd100;
    prod_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid%0d", c), 64'(acc_valid), 64'(1));
      chk($sformatf("bp_acc%0d", c), 64'(acc_out), 64'd16);
      chk($sformatf("bp_ready%0d", c), 64'(prod_ready), 64'(0));
      tick();
    end
    prod_valid = 1'b0;
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    chk("bp_released_valid", 64'(acc_valid), 64'(0));
    chk("bp_released_ready", 64'(prod_ready), 64'(1));
    chk("bp_not_busy", 64'(busy), 64'(0));
    frame_len = 8'd1;
    send(32'd3);
    get_res(r, o);
    chk("bp_after", r, 64'd3);

    // clear after 2 of 4 products; a product presented with clear is dropped
    frame_len = 8'd4;
    send(32'd1);
    send(32'd2);
    clear = 1'b1;
    prod_in = 32'd50;
    prod_valid = 1'b1;
    tick();
    clear = 1'b0;
    prod_valid = 1'b0;
    chk("clr_valid", 64'(acc_valid), 64'(0));
    chk("clr_busy", 64'(busy), 64'(0));
    chk("clr_acc_out_kept", 64'(acc_out), 64'd3);
    frame_len = 8'd2;
    send(32'd3);
    send(32'd4);
    get_res(r, o);
    chk("clr_next", r, 64'd7);

    // Narrow accumulator overflow
    b_frame_len = 8'd5;
    for (int k = 0; k < 5; k++) b_send(32'hFFFFFFFF);
    b_get(r, o);
    chk("w34_acc", r, 64'h0FFFFFFFB);
    chk("w34_ovf", 64'(o), 64'(1));
    b_frame_len = 8'd1;
    b_send(32'd1);
    b_get(r, o);
    chk("w34_next_acc", r, 64'd1);
    chk("w34_next_ovf", 64'(o), 64'(0));

    // Randomized frames against a plain-sum model, with stalls, mid-frame
    // frame_len scribbles and delayed acc_ready
    last = 64'(acc_out);
    for (int f = 0; f < 30; f++) begin
      int          len;
      int          n;
      logic [63:0] total;
      len = $urandom_range(0, 7);
      n = (len == 0) ? 1 : len;
      total = '0;
      frame_len = 8'(len);
      for (int k = 0; k < n; k++) begin
        logic [31:0] p;
        p = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : 32'($urandom);
        total += 64'(p);
        repeat ($urandom_range(0, 2)) tick();
        send(p);
        if (k == 0) frame_len = 8'($urandom);
      end
      repeat ($urandom_range(0, 3)) tick();
      get_res(r, o);
      chk($sformatf("rnd%0d_acc", f), r, total & 64'hFF_FFFF_FFFF);
      chk($sformatf("rnd%0d_ovf", f), 64'(o), 64'((total >> 40) != 0));
      last = r;
    end
    chk("rnd_final_idle", 64'(acc_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always reaches a conclusion
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
